// File: rtl/mips_pkg.sv
// Shared constants and types for the 5-stage MIPS core.
// Default widths, ALU operation encodings and the hard-wired zero register.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctl_e;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic [2:0] alu_control;
    } ctrl_t;
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Bundle between decode/memory stages and the ID/EX register.
// The stage register is the slave; the surrounding pipeline is the master.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = mips_pkg::CNT_W
);
    import mips_pkg::*;

    logic              ValidD;
    logic              RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
    logic [2:0]        ALUControlD;
    logic [DATA_W-1:0] RD1D, RD2D, SignImmD;
    logic [REG_AW-1:0] RsD, RtD, RdD;
    logic              MemtoRegM;
    logic [REG_AW-1:0] WriteRegM;
    logic              FlushE;

    logic              StallF, StallD;
    logic              RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE;
    logic [2:0]        ALUControlE;
    logic [DATA_W-1:0] RD1E, RD2E, SignImmE;
    logic [REG_AW-1:0] RsE, RtE, RdE;
    logic [REG_AW-1:0] WriteRegE;
    logic [CNT_W-1:0]  StallCnt;

    modport master (
        output ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
               ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, MemtoRegM, WriteRegM, FlushE,
        input  StallF, StallD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE,
               ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, StallCnt
    );

    modport slave (
        input  ValidD, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
               ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD, MemtoRegM, WriteRegM, FlushE,
        output StallF, StallD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ValidE,
               ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE, StallCnt
    );
endinterface

// File: rtl/hazard_stall_detect.sv
// Combinational load-use and branch-operand interlock detection.
// Register 0 is never a dependency since it is hard-wired to zero.
module hazard_stall_detect
    import mips_pkg::*;
#(
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              valid_d,
    input  logic              branch_d,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              memto_reg_e,
    input  logic              reg_write_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic              memto_reg_m,
    input  logic [REG_AW-1:0] write_reg_m,
    output logic              lwstall,
    output logic              brstall
);
    function automatic logic hits(input logic [REG_AW-1:0] dst, input logic [REG_AW-1:0] src);
        return (src != REG_AW'(ZERO_REG)) && (dst == src);
    endfunction

    logic e_load_dep;
    logic e_alu_dep;
    logic m_load_dep;

    always_comb begin
        e_load_dep = memto_reg_e & (hits(rt_e, rs_d) | hits(rt_e, rt_d));
        e_alu_dep  = reg_write_e & (hits(write_reg_e, rs_d) | hits(write_reg_e, rt_d));
        m_load_dep = memto_reg_m & (hits(write_reg_m, rs_d) | hits(write_reg_m, rt_d));
        lwstall    = valid_d & e_load_dep;
        // Branches resolve in D, so they also wait on an E-stage result or an M-stage load.
        brstall    = valid_d & branch_d & (e_alu_dep | m_load_dep);
    end
endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode->Execute pipeline register with embedded stall interlock and
// a saturating stall-cycle counter for performance debug.
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = mips_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    id_ex_stage_reg_if.slave      bus
);
    ctrl_t             ctrl_reg;
    logic              valid_reg;
    logic [DATA_W-1:0] rd1_reg, rd2_reg, imm_reg;
    logic [REG_AW-1:0] rs_reg, rt_reg, rd_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              lwstall, brstall, stall, bubble;
    logic [REG_AW-1:0] write_reg_e;
    ctrl_t             ctrl_d;

    assign write_reg_e = ctrl_reg.reg_dst ? rd_reg : rt_reg;

    hazard_stall_detect #(.REG_AW(REG_AW)) u_hazard (
        .valid_d     (bus.ValidD),
        .branch_d    (bus.BranchD),
        .rs_d        (bus.RsD),
        .rt_d        (bus.RtD),
        .memto_reg_e (ctrl_reg.memto_reg),
        .reg_write_e (ctrl_reg.reg_write),
        .rt_e        (rt_reg),
        .write_reg_e (write_reg_e),
        .memto_reg_m (bus.MemtoRegM),
        .write_reg_m (bus.WriteRegM),
        .lwstall     (lwstall),
        .brstall     (brstall)
    );

    assign stall  = lwstall | brstall;
    assign bubble = stall | bus.FlushE | ~bus.ValidD;

    always_comb begin
        ctrl_d             = '0;
        ctrl_d.reg_write   = bus.RegWriteD;
        ctrl_d.memto_reg   = bus.MemtoRegD;
        ctrl_d.mem_write   = bus.MemWriteD;
        ctrl_d.alu_src     = bus.ALUSrcD;
        ctrl_d.reg_dst     = bus.RegDstD;
        ctrl_d.alu_control = bus.ALUControlD;
    end

    // A bubble clears operands and fields too, so E never sees stale register numbers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg  <= '0;
            valid_reg <= 1'b0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
        end else if (bubble) begin
            ctrl_reg  <= '0;
            valid_reg <= 1'b0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
        end else begin
            ctrl_reg  <= ctrl_d;
            valid_reg <= 1'b1;
            rd1_reg   <= bus.RD1D;
            rd2_reg   <= bus.RD2D;
            imm_reg   <= bus.SignImmD;
            rs_reg    <= bus.RsD;
            rt_reg    <= bus.RtD;
            rd_reg    <= bus.RdD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (stall && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.StallF      = stall;
    assign bus.StallD      = stall;
    assign bus.RegWriteE   = ctrl_reg.reg_write;
    assign bus.MemtoRegE   = ctrl_reg.memto_reg;
    assign bus.MemWriteE   = ctrl_reg.mem_write;
    assign bus.ALUSrcE     = ctrl_reg.alu_src;
    assign bus.RegDstE     = ctrl_reg.reg_dst;
    assign bus.ALUControlE = ctrl_reg.alu_control;
    assign bus.ValidE      = valid_reg;
    assign bus.RD1E        = rd1_reg;
    assign bus.RD2E        = rd2_reg;
    assign bus.SignImmE    = imm_reg;
    assign bus.RsE         = rs_reg;
    assign bus.RtE         = rt_reg;
    assign bus.RdE         = rd_reg;
    assign bus.WriteRegE   = write_reg_e;
    assign bus.StallCnt    = cnt_reg;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against a transaction-level model.
module tb_id_ex_stage_reg;
    logic clk;
    logic reset_n;

    id_ex_stage_reg_if bus ();

    id_ex_stage_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        valid, rw, m2r, mw, asrc, rdst, br;
        bit [2:0]  alu;
        bit [31:0] rd1, rd2, imm;
        bit [4:0]  rs, rt, rd;
        bit        m2r_m;
        bit [4:0]  wr_m;
        bit        flush;
    } din_t;

    typedef struct {
        bit        valid, rw, m2r, mw, asrc, rdst;
        bit [2:0]  alu;
        bit [31:0] rd1, rd2, imm;
        bit [4:0]  rs, rt, rd;
    } e_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    e_t  e_exp;
    int  cnt_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit depends(input bit [4:0] dst, input bit [4:0] src);
        return (src != 0) && (dst == src);
    endfunction

    // Stall rule evaluated from the instruction currently in E and the incoming D/M state.
    function automatic bit model_stall(input din_t d, input e_t e);
        bit [4:0] wr_e;
        bit lw, brs;
        wr_e = e.rdst ? e.rd : e.rt;
        lw  = e.m2r && (depends(e.rt, d.rs) || depends(e.rt, d.rt));
        brs = d.br && ((e.rw && (depends(wr_e, d.rs) || depends(wr_e, d.rt))) ||
                       (d.m2r_m && (depends(d.wr_m, d.rs) || depends(d.wr_m, d.rt))));
        return d.valid && (lw || brs);
    endfunction

    task automatic drive(input din_t d);
        bus.ValidD      = d.valid;
        bus.RegWriteD   = d.rw;
        bus.MemtoRegD   = d.m2r;
        bus.MemWriteD   = d.mw;
        bus.ALUSrcD     = d.asrc;
        bus.RegDstD     = d.rdst;
        bus.BranchD     = d.br;
        bus.ALUControlD = d.alu;
        bus.RD1D        = d.rd1;
        bus.RD2D        = d.rd2;
        bus.SignImmD    = d.imm;
        bus.RsD         = d.rs;
        bus.RtD         = d.rt;
        bus.RdD         = d.rd;
        bus.MemtoRegM   = d.m2r_m;
        bus.WriteRegM   = d.wr_m;
        bus.FlushE      = d.flush;
    endtask

    task automatic check_e();
        check("ValidE",      bus.ValidE,      e_exp.valid);
        check("RegWriteE",   bus.RegWriteE,   e_exp.rw);
        check("MemtoRegE",   bus.MemtoRegE,   e_exp.m2r);
        check("MemWriteE",   bus.MemWriteE,   e_exp.mw);
        check("ALUSrcE",     bus.ALUSrcE,     e_exp.asrc);
        check("RegDstE",     bus.RegDstE,     e_exp.rdst);
        check("ALUControlE", bus.ALUControlE, e_exp.alu);
        check("RD1E",        bus.RD1E,        e_exp.rd1);
        check("RD2E",        bus.RD2E,        e_exp.rd2);
        check("SignImmE",    bus.SignImmE,    e_exp.imm);
        check("RsE",         bus.RsE,         e_exp.rs);
        check("RtE",         bus.RtE,         e_exp.rt);
        check("RdE",         bus.RdE,         e_exp.rd);
        check("WriteRegE",   bus.WriteRegE,   e_exp.rdst ? e_exp.rd : e_exp.rt);
        check("StallCnt",    bus.StallCnt,    cnt_exp);
    endtask

    // One clock: drive D at negedge, check stall combinationally, advance model, check E.
    task automatic step(input din_t d, input bit show, output bit st);
        bit st_exp;
        @(negedge clk);
        drive(d);
        #1;
        st_exp = model_stall(d, e_exp);
        check("StallD", bus.StallD, st_exp);
        check("StallF", bus.StallF, st_exp);
        st = bus.StallD;
        @(posedge clk);
        if (st_exp || d.flush || !d.valid) begin
            e_exp = '{default: 0};
        end else begin
            e_exp.valid = 1'b1;
            e_exp.rw = d.rw;   e_exp.m2r = d.m2r;   e_exp.mw = d.mw;
            e_exp.asrc = d.asrc; e_exp.rdst = d.rdst; e_exp.alu = d.alu;
            e_exp.rd1 = d.rd1; e_exp.rd2 = d.rd2;   e_exp.imm = d.imm;
            e_exp.rs = d.rs;   e_exp.rt = d.rt;     e_exp.rd = d.rd;
        end
        if (st_exp) cnt_exp = (cnt_exp + 1 > 65535) ? 65535 : cnt_exp + 1;
        #1;
        check_e();
        if (show)
            $display("txn v=%0b br=%0b m2r=%0b rs=%0d rt=%0d rd=%0d m2rM=%0b wrM=%0d flush=%0b -> stall=%0b validE=%0b cnt=%0d",
                     d.valid, d.br, d.m2r, d.rs, d.rt, d.rd, d.m2r_m, d.wr_m, d.flush,
                     st, bus.ValidE, bus.StallCnt);
    endtask

    task automatic do_reset();
        din_t z;
        z = '{default: 0};
        @(negedge clk);
        drive(z);
        reset_n = 1'b0;
        e_exp   = '{default: 0};
        cnt_exp = 0;
        #1;
        check_e();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic din_t rand_op();
        din_t d;
        d.valid = ($urandom_range(0, 99) < 85);
        d.rw    = $urandom_range(0, 1);
        d.m2r   = ($urandom_range(0, 99) < 30);
        d.mw    = $urandom_range(0, 1);
        d.asrc  = $urandom_range(0, 1);
        d.rdst  = $urandom_range(0, 1);
        d.br    = ($urandom_range(0, 99) < 25);
        d.alu   = 3'($urandom_range(0, 7));
        d.rd1   = $urandom;
        d.rd2   = $urandom;
        d.imm   = $urandom;
        d.rs    = 5'($urandom_range(0, 3));
        d.rt    = 5'($urandom_range(0, 3));
        d.rd    = 5'($urandom_range(0, 3));
        d.m2r_m = ($urandom_range(0, 99) < 30);
        d.wr_m  = 5'($urandom_range(0, 3));
        d.flush = ($urandom_range(0, 99) < 10);
        return d;
    endfunction

    function automatic din_t op(input bit m2r, input bit rw, input bit br,
                                input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        din_t d;
        d = '{default: 0};
        d.valid = 1'b1; d.m2r = m2r; d.rw = rw; d.br = br;
        d.rs = rs; d.rt = rt; d.rd = rd;
        d.alu = m2r ? 3'b010 : 3'b110;
        d.rd1 = 32'h1000_0000 + rs; d.rd2 = 32'h2000_0000 + rt; d.imm = 32'hFFFF_FF00 + rd;
        return d;
    endfunction

    initial begin
        din_t d;
        bit   st;
        reset_n = 1'b0;
        drive('{default: 0});
        e_exp   = '{default: 0};
        cnt_exp = 0;
        #1;
        check_e();
        do_reset();

        // Stream random ops, then drop reset in the middle of a cycle.
        for (int i = 0; i < 30; i++) step(rand_op(), 1'b1, st);
        #2;
        reset_n = 1'b0;
        e_exp   = '{default: 0};
        cnt_exp = 0;
        #1;
        check_e();
        @(negedge clk);
        reset_n = 1'b1;

        // Load-use on RsD: one stall, bubble, then the add enters.
        do_reset();
        step(op(1, 1, 0, 5'd1, 5'd8, 5'd0), 1'b1, st);
        step(op(0, 1, 0, 5'd8, 5'd2, 5'd3), 1'b1, st);
        check("t2_stall", st, 1);
        check("t2_bubble_valid", bus.ValidE, 0);
        step(op(0, 1, 0, 5'd8, 5'd2, 5'd3), 1'b1, st);
        check("t2_nostall", st, 0);
        check("t2_rsE", bus.RsE, 8);
        check("t2_cnt", bus.StallCnt, 1);

        // Load into r0 never creates a dependency.
        do_reset();
        step(op(1, 1, 0, 5'd1, 5'd0, 5'd0), 1'b1, st);
        step(op(0, 1, 0, 5'd0, 5'd0, 5'd4), 1'b1, st);
        check("t3_nostall", st, 0);
        check("t3_validE", bus.ValidE, 1);

        // Load then dependent beq: E-stage then M-stage match.
        do_reset();
        step(op(1, 1, 0, 5'd2, 5'd9, 5'd0), 1'b1, st);
        d = op(0, 0, 1, 5'd9, 5'd3, 5'd0);
        step(d, 1'b1, st);
        check("t4_stall1", st, 1);
        d.m2r_m = 1'b1; d.wr_m = 5'd9;
        step(d, 1'b1, st);
        check("t4_stall2", st, 1);
        d.m2r_m = 1'b0; d.wr_m = 5'd0;
        step(d, 1'b1, st);
        check("t4_stall3", st, 0);
        check("t4_rsE", bus.RsE, 9);
        check("t4_cnt", bus.StallCnt, 2);

        // Flush coinciding with a load-use stall gives a single bubble.
        do_reset();
        step(op(1, 1, 0, 5'd1, 5'd4, 5'd0), 1'b1, st);
        d = op(0, 1, 0, 5'd4, 5'd5, 5'd6);
        d.flush = 1'b1;
        step(d, 1'b1, st);
        check("t5_stall", st, 1);
        check("t5_validE", bus.ValidE, 0);
        check("t5_cnt", bus.StallCnt, 1);

        // Random stream against the model.
        do_reset();
        for (int i = 0; i < 400; i++) step(rand_op(), 1'b1, st);

        // Hold an M-stage load dependency on a branch long enough to saturate.
        do_reset();
        d = op(0, 0, 1, 5'd7, 5'd0, 5'd0);
        d.m2r_m = 1'b1; d.wr_m = 5'd7;
        for (int i = 0; i < 65540; i++) step(d, 1'b0, st);
        check("t6_sat", bus.StallCnt, 16'hFFFF);
        d.m2r_m = 1'b0;
        step(d, 1'b1, st);
        check("t6_hold", bus.StallCnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
